// File: rtl/lcd_text_sequencer_if.sv
// Host write port and LCD controller handshake
// for the character-LCD text sequencer.
interface lcd_text_sequencer_if;
  logic       iWR;
  logic [4:0] iADDR;
  logic [7:0] iWDATA;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_START;
  logic       iLCD_DONE;
  logic       oINIT_DONE;

  modport master (
    output iWR, iADDR, iWDATA, iLCD_DONE,
    input  oLCD_DATA, oLCD_RS, oLCD_START,
    input  oINIT_DONE
  );

  modport slave (
    input  iWR, iADDR, iWDATA, iLCD_DONE,
    output oLCD_DATA, oLCD_RS, oLCD_START,
    output oINIT_DONE
  );
endinterface

// File: rtl/lcd_text_sequencer.sv
// HD44780 init + continuous 2x16 refresh
// sequencer feeding the LCD byte-write controller.
module lcd_text_sequencer #(
  parameter logic [17:0] CMD_DELAY = 18'h3FFFF
) (
  input logic iCLK,
  input logic iRST_N,
  lcd_text_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_DELAY,
    S_LOAD,
    S_PULSE,
    S_ARM,
    S_WAIT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [17:0] cnt;
  logic [5:0]  idx;
  logic [5:0]  idx_nx;
  logic [7:0]  mem [32];
  logic [7:0]  sel_data;
  logic        sel_rs;
  logic [5:0]  off5;
  logic [5:0]  off6;
  logic        cnt_hit;
  logic        xfer_done;

  assign cnt_hit   = (cnt == CMD_DELAY);
  assign xfer_done = (state == S_WAIT) &&
                     bus.iLCD_DONE;
  assign off5      = idx - 6'd5;
  assign off6      = idx - 6'd6;
  assign idx_nx    = (idx == 6'd37) ? 6'd4
                                    : idx + 6'd1;

  // Host writes land in every state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= 8'h20;
    end else if (bus.iWR) begin
      mem[bus.iADDR] <= bus.iWDATA;
    end
  end

  // Map sequence index to command or character.
  always_comb begin
    sel_data = 8'h20;
    sel_rs   = 1'b1;
    unique case (1'b1)
      (idx == 6'd0): begin
        sel_data = 8'h38;
        sel_rs   = 1'b0;
      end
      (idx == 6'd1): begin
        sel_data = 8'h0C;
        sel_rs   = 1'b0;
      end
      (idx == 6'd2): begin
        sel_data = 8'h01;
        sel_rs   = 1'b0;
      end
      (idx == 6'd3): begin
        sel_data = 8'h06;
        sel_rs   = 1'b0;
      end
      (idx == 6'd4): begin
        sel_data = 8'h80;
        sel_rs   = 1'b0;
      end
      (idx >= 6'd5 && idx <= 6'd20): begin
        sel_data = mem[off5[4:0]];
        sel_rs   = 1'b1;
      end
      (idx == 6'd21): begin
        sel_data = 8'hC0;
        sel_rs   = 1'b0;
      end
      default: begin
        sel_data = mem[off6[4:0]];
        sel_rs   = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      state <= S_DELAY;
    else
      state <= state_nx;
  end

  // Next-state logic; done is only heard in WAIT.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_DELAY: if (cnt_hit) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_PULSE;
      S_PULSE: state_nx = S_ARM;
      S_ARM:   state_nx = S_WAIT;
      S_WAIT:  if (bus.iLCD_DONE)
                 state_nx = S_DELAY;
      default: state_nx = S_DELAY;
    endcase
  end

  // Inter-byte delay counter, idle outside DELAY.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      cnt <= '0;
    else if (state == S_DELAY && !cnt_hit)
      cnt <= cnt + 18'd1;
    else
      cnt <= '0;
  end

  // Sequence index; init runs once, refresh loops.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      idx <= '0;
    else if (xfer_done)
      idx <= idx_nx;
  end

  // Registered controller outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bus.oLCD_DATA  <= '0;
      bus.oLCD_RS    <= 1'b0;
      bus.oLCD_START <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          bus.oLCD_DATA <= sel_data;
          bus.oLCD_RS   <= sel_rs;
        end
        S_PULSE: bus.oLCD_START <= 1'b1;
        S_WAIT:  bus.oLCD_START <= 1'b0;
        default: ;
      endcase
    end
  end

  // Sticky flag once the first home command lands.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      bus.oINIT_DONE <= 1'b0;
    else if (xfer_done && idx == 6'd4)
      bus.oINIT_DONE <= 1'b1;
  end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed bench for lcd_text_sequencer with a
// behavioural LCD controller model.
module tb_lcd_text_sequencer;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;

  lcd_text_sequencer_if bus ();

  lcd_text_sequencer #(
    .CMD_DELAY (18'd4)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  int vectors = 0;
  int fails = 0;

  // controller model: 0 normal, 1 done held, 2 never
  int       mode = 0;
  logic     done = 1'b1;
  logic     st_q = 1'b0;
  int       dcnt = 0;
  int       hl = 0;
  int       cyc = 0;
  logic [8:0] xq [$];
  int       tq [$];
  int       hq [$];
  logic [7:0] em [32];

  assign bus.iLCD_DONE = done;

  always @(posedge iCLK) begin
    cyc <= cyc + 1;
    if (!iRST_N) begin
      st_q <= 1'b0;
      hl   <= 0;
      dcnt <= 0;
      done <= (mode == 1);
    end else begin
      st_q <= bus.oLCD_START;
      if (bus.oLCD_START && !st_q) begin
        xq.push_back({bus.oLCD_RS,
                      bus.oLCD_DATA});
        tq.push_back(cyc);
      end
      if (bus.oLCD_START)
        hl <= hl + 1;
      else if (hl != 0) begin
        hq.push_back(hl);
        hl <= 0;
      end
      if (mode == 1)
        done <= 1'b1;
      else if (mode == 2)
        done <= 1'b0;
      else if (bus.oLCD_START && !st_q) begin
        done <= 1'b0;
        dcnt <= 1;
      end else if (dcnt != 0) begin
        if (dcnt == 20) begin
          done <= 1'b1;
          dcnt <= 0;
        end else
          dcnt <= dcnt + 1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_byte(int k);
    int i;
    i = (k < 38) ? k : 4 + ((k - 38) % 34);
    case (i)
      0:  return {1'b0, 8'h38};
      1:  return {1'b0, 8'h0C};
      2:  return {1'b0, 8'h01};
      3:  return {1'b0, 8'h06};
      4:  return {1'b0, 8'h80};
      21: return {1'b0, 8'hC0};
      default:
        if (i <= 20) return {1'b1, em[i-5]};
        else         return {1'b1, em[i-6]};
    endcase
  endfunction

  task automatic wait_xfers(input int n,
                            input string tag);
    int b = 4000;
    while (xq.size() < n && b > 0) begin
      @(posedge iCLK); #1;
      b--;
    end
    check({tag, "_count"}, xq.size(), n);
  endtask

  task automatic check_out_zero(input string t);
    check({t, "_data"}, bus.oLCD_DATA, 8'h00);
    check({t, "_rs"}, bus.oLCD_RS, 1'b0);
    check({t, "_start"}, bus.oLCD_START, 1'b0);
    check({t, "_init"}, bus.oINIT_DONE, 1'b0);
  endtask

  task automatic do_reset(input int m);
    iRST_N = 1'b0;
    mode = m;
    #1;
    check_out_zero("rst");
    xq.delete();
    tq.delete();
    hq.delete();
    for (int i = 0; i < 32; i++) em[i] = 8'h20;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  task automatic host_wr(input logic [4:0] a,
                         input logic [7:0] d);
    @(negedge iCLK);
    bus.iWR = 1'b1;
    bus.iADDR = a;
    bus.iWDATA = d;
    em[a] = d;
    @(negedge iCLK);
    bus.iWR = 1'b0;
  endtask

  initial begin
    int b;
    bus.iWR = 1'b0;
    bus.iADDR = '0;
    bus.iWDATA = '0;

    // A: reset, no writes, full first pass
    do_reset(0);
    repeat (5) @(posedge iCLK);
    #1;
    check("first_load_early", bus.oLCD_DATA, 8'h00);
    @(posedge iCLK); #1;
    check("first_load_data", bus.oLCD_DATA, 8'h38);
    check("first_load_start", bus.oLCD_START, 1'b0);
    @(posedge iCLK); #1;
    check("first_start_rise", bus.oLCD_START, 1'b1);
    wait_xfers(5, "a5");
    check("init_before", bus.oINIT_DONE, 1'b0);
    wait_xfers(6, "a6");
    check("init_after", bus.oINIT_DONE, 1'b1);
    wait_xfers(39, "a39");
    for (int k = 0; k < 39; k++)
      check($sformatf("a_byte%0d", k),
            xq[k], exp_byte(k));

    // B: HELLO on line 1 before init completes
    do_reset(0);
    host_wr(5'd0, 8'h48);
    host_wr(5'd1, 8'h45);
    host_wr(5'd2, 8'h4C);
    host_wr(5'd3, 8'h4C);
    host_wr(5'd4, 8'h4F);
    wait_xfers(22, "b22");
    for (int k = 5; k < 22; k++)
      check($sformatf("b_byte%0d", k),
            xq[k], exp_byte(k));

    // C: write addr 16 in the LOAD cycle of idx 22
    b = 200;
    while (!(xq.size() == 22 && done) && b > 0) begin
      @(posedge iCLK); #1;
      b--;
    end
    check("c_sync", {31'd0, done}, 32'd1);
    repeat (6) @(posedge iCLK);
    #1;
    bus.iWR = 1'b1;
    bus.iADDR = 5'd16;
    bus.iWDATA = 8'h41;
    @(posedge iCLK); #1;
    bus.iWR = 1'b0;
    wait_xfers(57, "c57");
    check("c_same_cycle", xq[22], {1'b1, 8'h20});
    check("c_home", xq[38], {1'b0, 8'h80});
    check("c_h_again", xq[39], {1'b1, 8'h48});
    check("c_next_pass", xq[56], {1'b1, 8'h41});

    // D: done held high, fixed 9-cycle period
    do_reset(1);
    wait_xfers(12, "d12");
    for (int k = 0; k < 12; k++)
      check($sformatf("d_byte%0d", k),
            xq[k], exp_byte(k));
    for (int k = 1; k < 12; k++)
      check($sformatf("d_period%0d", k),
            tq[k] - tq[k-1], 9);
    for (int k = 0; k < 11; k++)
      check($sformatf("d_hi%0d", k), hq[k], 2);

    // E: done never rises, stall in WAIT
    do_reset(2);
    wait_xfers(1, "e1");
    repeat (100) @(posedge iCLK);
    #1;
    check("e_stall_cnt", xq.size(), 1);
    check("e_stall_start", bus.oLCD_START, 1'b0);
    check("e_stall_data", bus.oLCD_DATA, 8'h38);
    check("e_stall_rs", bus.oLCD_RS, 1'b0);
    do_reset(2);
    repeat (5) @(posedge iCLK);
    #1;
    check("e_restart_early", bus.oLCD_DATA, 8'h00);
    @(posedge iCLK); #1;
    check("e_restart_data", bus.oLCD_DATA, 8'h38);

    // F: reset mid-transfer of idx 10
    do_reset(0);
    host_wr(5'd0, 8'h5A);
    host_wr(5'd20, 8'h51);
    wait_xfers(11, "f11");
    check("f_idx10", xq[10], {1'b1, 8'h20});
    check("f_init_set", bus.oINIT_DONE, 1'b1);
    #3;
    iRST_N = 1'b0;
    #1;
    check_out_zero("f_async");
    do_reset(0);
    wait_xfers(38, "f38");
    for (int k = 0; k < 38; k++)
      check($sformatf("f_byte%0d", k),
            xq[k], exp_byte(k));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
